// File: rtl/display_pkg.sv
// Shared types, constants and helpers for the count display.
// Holds FSM encoding, segment table and double-dabble adjust.
package display_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a}, entry 15 first.
    localparam logic [15:0][6:0] SEG_TAB = {
        7'h0E, 7'h06, 7'h21, 7'h46,
        7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19,
        7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic logic [19:0] dd_adjust(
        input logic [19:0] b
    );
        logic [19:0] r;
        r = b;
        for (int i = 0; i < 5; i++) begin
            if (r[4*i +: 4] >= 4'd5)
                r[4*i +: 4] = r[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

endpackage

// File: rtl/count_display_if.sv
// Value input and display output bundle.
// master drives the value/mode side, slave is the display.
interface count_display_if;
    logic [15:0] value;
    logic        dec_mode;
    logic        blank_lz;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    modport master (
        output value, dec_mode, blank_lz,
        input  an, seg, dp
    );

    modport slave (
        input  value, dec_mode, blank_lz,
        output an, seg, dp
    );
endinterface

// File: rtl/bin2bcd16.sv
// Sequential 16-bit binary to 5-digit BCD converter.
// One double-dabble step per cycle, 16 steps per conversion.
module bin2bcd16
    import display_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] bin,
    output logic        busy,
    output logic        done,
    output logic [19:0] bcd
);

    logic [15:0] sh;
    logic [19:0] acc;
    logic [19:0] adj;
    logic [3:0]  cnt;
    logic        run;

    // Add-3 correction applied before each shift.
    always_comb begin
        adj = dd_adjust(acc);
    end

    // Load on start, then shift one binary bit in per cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh  <= '0;
            acc <= '0;
            cnt <= '0;
            run <= 1'b0;
        end else if (start) begin
            sh  <= bin;
            acc <= '0;
            cnt <= '0;
            run <= 1'b1;
        end else if (run) begin
            acc <= {adj[18:0], sh[15]};
            sh  <= {sh[14:0], 1'b0};
            cnt <= cnt + 4'd1;
            if (cnt == 4'd15)
                run <= 1'b0;
        end
    end

    assign busy = run;
    assign done = run && (cnt == 4'd15);
    assign bcd  = acc;

endmodule

// File: rtl/count_display.sv
// Samples a 16-bit value once per frame and scans it
// onto a 4-digit multiplexed seven-segment display.
module count_display
    import display_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input logic            clk,
    input logic            reset,
    count_display_if.slave bus
);

    localparam int PW = $clog2(REFRESH_DIV);

    logic [PW-1:0]   presc;
    logic            tick;
    logic [1:0]      idx;
    state_t          state;
    logic [15:0]     shadow;
    logic            shadow_dec;
    logic [3:0][3:0] dig;
    logic            ovf;
    logic            start;
    logic            eng_busy;
    logic            eng_done;
    logic [19:0]     bcd;
    logic            blank;
    logic [3:0]      an_q;
    logic [6:0]      seg_q;
    logic            dp_q;

    assign tick  = (presc == PW'(REFRESH_DIV - 1));
    assign start = (state == IDLE) && tick && (idx == 2'd3);

    // Prescaler and digit scan index.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc <= '0;
            idx   <= '0;
        end else if (tick) begin
            presc <= '0;
            idx   <= idx + 2'd1;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    bin2bcd16 u_bcd (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .bin   (bus.value),
        .busy  (eng_busy),
        .done  (eng_done),
        .bcd   (bcd)
    );

    // Capture at frame wrap, convert, then load display regs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            shadow     <= '0;
            shadow_dec <= 1'b0;
            dig        <= '0;
            ovf        <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        shadow     <= bus.value;
                        shadow_dec <= bus.dec_mode;
                        state      <= CONV;
                    end
                end
                CONV: begin
                    if (eng_done)
                        state <= DONE;
                end
                DONE: begin
                    if (shadow_dec) begin
                        dig <= bcd[15:0];
                        ovf <= (bcd[19:16] != 4'd0);
                    end else begin
                        dig <= shadow;
                        ovf <= 1'b0;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Slot is blank when it and every higher digit are zero.
    always_comb begin
        blank = bus.blank_lz && (idx != 2'd0);
        for (int k = 0; k < 4; k++) begin
            if (k >= int'(idx) && dig[k] != 4'd0)
                blank = 1'b0;
        end
    end

    // Registered anode, segment and decimal point drive.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an_q  <= 4'b1111;
            seg_q <= SEG_BLANK;
            dp_q  <= 1'b1;
        end else if (blank) begin
            an_q  <= 4'b1111;
            seg_q <= SEG_BLANK;
            dp_q  <= 1'b1;
        end else begin
            an_q  <= ~(4'b0001 << idx);
            seg_q <= SEG_TAB[dig[idx]];
            dp_q  <= ~ovf;
        end
    end

    assign bus.an  = an_q;
    assign bus.seg = seg_q;
    assign bus.dp  = dp_q;

endmodule

// File: tb/tb_count_display.sv
// Self-checking bench for count_display.
// Checks scanned digits against an arithmetic display model.
module tb_count_display;

    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    count_display_if ifc ();

    count_display #(.REFRESH_DIV(20)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    int checks = 0;
    int failures = 0;

    logic [6:0] segtab [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic int model_digit(
        input int v, input bit dec, input int k
    );
        if (dec)
            return ((v % 10000) / (10 ** k)) % 10;
        return (v >> (4 * k)) & 15;
    endfunction

    function automatic bit model_ovf(input int v, input bit dec);
        return dec && (v > 9999);
    endfunction

    function automatic bit model_shown(
        input int v, input bit dec, input bit blz, input int k
    );
        if (!blz || k == 0)
            return 1'b1;
        for (int j = k; j < 4; j++)
            if (model_digit(v, dec, j) != 0)
                return 1'b1;
        return 1'b0;
    endfunction

    task automatic set_in(input int v, input bit dec, input bit blz);
        ifc.value    = v[15:0];
        ifc.dec_mode = dec;
        ifc.blank_lz = blz;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Sample 80 cycles (one frame) and compare each digit slot.
    task automatic check_frame(
        input int v, input bit dec, input bit blz, input string name
    );
        bit         seen [4];
        logic [6:0] sseg [4];
        logic       sdp  [4];
        int         bad;
        int         hit;
        logic [3:0] p;
        logic [6:0] eseg;
        logic       edp;
        bit         eshow;
        bad = 0;
        for (int k = 0; k < 4; k++) seen[k] = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk);
            #1;
            if (ifc.an !== 4'b1111) begin
                hit = -1;
                for (int k = 0; k < 4; k++) begin
                    p = 4'b0001 << k;
                    if (ifc.an === ~p) hit = k;
                end
                if (hit < 0) begin
                    bad++;
                end else begin
                    if (seen[hit] && (sseg[hit] !== ifc.seg
                        || sdp[hit] !== ifc.dp))
                        bad++;
                    seen[hit] = 1'b1;
                    sseg[hit] = ifc.seg;
                    sdp[hit]  = ifc.dp;
                end
            end
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL %s an_pattern bad=%0d want 0", name, bad);
        end
        for (int k = 0; k < 4; k++) begin
            eshow = model_shown(v, dec, blz, k);
            checks++;
            if (seen[k] !== eshow) begin
                failures++;
                $display("FAIL %s shown[%0d] got %0b want %0b",
                    name, k, seen[k], eshow);
            end
            if (eshow && seen[k]) begin
                eseg = segtab[model_digit(v, dec, k)];
                edp  = ~model_ovf(v, dec);
                checks++;
                if (sseg[k] !== eseg) begin
                    failures++;
                    $display("FAIL %s seg[%0d] got %h want %h",
                        name, k, sseg[k], eseg);
                end
                checks++;
                if (sdp[k] !== edp) begin
                    failures++;
                    $display("FAIL %s dp[%0d] got %b want %b",
                        name, k, sdp[k], edp);
                end
            end
        end
    endtask

    task automatic check_idle_outputs(input string name);
        checks++;
        if (ifc.an !== 4'b1111 || ifc.seg !== 7'h7F
            || ifc.dp !== 1'b1) begin
            failures++;
            $display("FAIL %s got an=%b seg=%h dp=%b want 1111/7f/1",
                name, ifc.an, ifc.seg, ifc.dp);
        end
    endtask

    task automatic test_reset();
        set_in(16'hFFFF, 1'b1, 1'b1);
        reset = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            check_idle_outputs("reset_hold");
        end
        reset = 1'b0;
        check_frame(0, 1'b1, 1'b1, "reset_first_frame");
    endtask

    task automatic test_decimal();
        int n;
        set_in(1234, 1'b1, 1'b0);
        do_reset();
        n = 0;
        while (n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (ifc.seg !== 7'h40) break;
        end
        checks++;
        if (n != 98) begin
            failures++;
            $display("FAIL dec_latency got %0d want 98", n);
        end
        check_frame(1234, 1'b1, 1'b0, "dec_1234");
    endtask

    task automatic test_hex();
        set_in(16'hBEEF, 1'b0, 1'b0);
        repeat (240) @(posedge clk);
        check_frame(16'hBEEF, 1'b0, 1'b0, "hex_beef");
    endtask

    task automatic test_overflow();
        set_in(65535, 1'b1, 1'b0);
        repeat (240) @(posedge clk);
        check_frame(65535, 1'b1, 1'b0, "ovf_65535");
        set_in(9999, 1'b1, 1'b0);
        repeat (240) @(posedge clk);
        check_frame(9999, 1'b1, 1'b0, "dec_9999");
    endtask

    task automatic test_blanking();
        set_in(7, 1'b1, 1'b1);
        repeat (240) @(posedge clk);
        check_frame(7, 1'b1, 1'b1, "blank_7");
        set_in(0, 1'b1, 1'b1);
        repeat (240) @(posedge clk);
        check_frame(0, 1'b1, 1'b1, "blank_0");
    endtask

    task automatic test_mid_change();
        set_in(100, 1'b1, 1'b0);
        do_reset();
        repeat (85) @(posedge clk);
        #1;
        set_in(200, 1'b1, 1'b0);
        repeat (12) @(posedge clk);
        check_frame(100, 1'b1, 1'b0, "mid_old");
        check_frame(200, 1'b1, 1'b0, "mid_new");
    endtask

    task automatic test_reset_mid_conv();
        set_in(4321, 1'b1, 1'b0);
        do_reset();
        repeat (85) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check_idle_outputs("rst_mid_async");
        @(negedge clk);
        @(negedge clk);
        check_idle_outputs("rst_mid_hold");
        reset = 1'b0;
        repeat (97) @(posedge clk);
        check_frame(4321, 1'b1, 1'b0, "rst_mid_after");
    endtask

    task automatic test_random();
        int v;
        bit dec;
        bit blz;
        for (int i = 0; i < 8; i++) begin
            v   = int'($urandom_range(0, 65535));
            if (i % 3 == 0) v = v % 100;
            dec = 1'($urandom_range(0, 1));
            blz = 1'($urandom_range(0, 1));
            set_in(v, dec, blz);
            repeat (240) @(posedge clk);
            check_frame(v, dec, blz, "random");
        end
    endtask

    initial begin
        set_in(0, 1'b0, 1'b0);
        test_reset();
        test_decimal();
        test_hex();
        test_overflow();
        test_blanking();
        test_mid_change();
        test_reset_mid_conv();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d",
            checks, failures);
        $finish;
    end

endmodule
